// File: rtl/mul8_pkg.sv
// mul8_pkg: shared definitions for the 8x8 multiply scheduler.
//   - state_t        : scheduler state encoding (IDLE..DONE)
//   - SHIFT_*        : shifter control codes (<<0, <<4, <<8)
//   - STEP_*         : per-step nibble select / shift lookup, bit k = step k
//   - step_live()    : which of the four partial-product steps do real work
//   - first_live()   : lowest live step at or above a starting index
package mul8_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    MUL  = 3'd2,
    DISP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] SHIFT_0 = 2'd0;
  localparam logic [1:0] SHIFT_4 = 2'd1;
  localparam logic [1:0] SHIFT_8 = 2'd2;

  // Step k: sela = STEP_SELA[k], selb = STEP_SELB[k], shift = STEP_SHIFT[2k+:2]
  localparam logic [3:0] STEP_SELA  = 4'b1100;
  localparam logic [3:0] STEP_SELB  = 4'b1010;
  localparam logic [7:0] STEP_SHIFT = {SHIFT_8, SHIFT_4, SHIFT_4, SHIFT_0};

  // Returned by first_live() when no step remains.
  localparam logic [2:0] NO_STEP = 3'd4;

  // nz = {b_hi, b_lo, a_hi, a_lo} zero flags. A step is live only when
  // both of the nibbles it multiplies are non-zero.
  function automatic logic [3:0] step_live(input logic [3:0] nz);
    logic [3:0] live;
    logic       a_z;
    logic       b_z;
    live = 4'h0;
    for (int k = 0; k < 4; k++) begin
      a_z     = STEP_SELA[k] ? nz[1] : nz[0];
      b_z     = STEP_SELB[k] ? nz[3] : nz[2];
      live[k] = !(a_z || b_z);
    end
    return live;
  endfunction

  function automatic logic [2:0] first_live(input logic [3:0] live,
                                            input logic [2:0] start);
    logic [2:0] r;
    r = NO_STEP;
    // Scan downward so the lowest qualifying index is the one kept.
    for (int k = 3; k >= 0; k--) begin
      if (live[k] && (3'(k) >= start)) r = 3'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/mul8_rr_arb.sv
// mul8_rr_arb: two-requester round-robin arbiter (combinational).
//   req    : level requests, bit i = requester i
//   rr_ptr : requester favoured when both request
//   grant  : at least one request present
//   owner  : winning requester index
module mul8_rr_arb (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       grant,
  output logic       owner
);

  always_comb begin
    grant = |req;
    case (req)
      2'b11:   owner = rr_ptr;
      2'b10:   owner = 1'b1;
      default: owner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul8_rr_sched.sv
// mul8_rr_sched: round-robin scheduler / sequencer for the shared 8x8
// multiply datapath. Grants one of two requesters, clears the accumulator,
// runs the four nibble partial-product steps, loads DISP_DIGITS display
// digits, then pulses done/ack to the served requester.
//
// Ports:
//   clk, rst (sync, active-low)   req[1:0] level requests
//   nib_zero[3:0] {b_hi,b_lo,a_hi,a_lo} zero flags (ZERO_SKIP_EN only)
//   op_sel, input_sela, input_selb, shift_sel[1:0] : datapath steering
//   acc_clr, acc_en : accumulator control
//   seg_mux_sel[2:0], seg_ld : display digit load
//   busy, done, ack[1:0] : status; ack is one-hot and coincident with done
//   state_dbg[2:0] : current scheduler state
//
// Handshake: req[i] is a level held by the requester until ack[i] pulses for
// one cycle; the scheduler samples req only in IDLE, so dropping req while
// busy does not cancel the operation and a req raised while busy waits.
//
// Build option: define ZERO_SKIP_EN to skip MUL steps whose nibble pair
// contains a zero nibble (nib_zero sampled in CLR).
module mul8_rr_sched
  import mul8_pkg::*;
#(
  parameter int DISP_DIGITS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] nib_zero,
  output logic       op_sel,
  output logic       input_sela,
  output logic       input_selb,
  output logic [1:0] shift_sel,
  output logic       acc_clr,
  output logic       acc_en,
  output logic [2:0] seg_mux_sel,
  output logic       seg_ld,
  output logic       busy,
  output logic       done,
  output logic [1:0] ack,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LAST_DIGIT = 3'(DISP_DIGITS - 1);

  state_t     state_q;
  logic       owner_q;
  logic       rr_ptr_q;
  logic [1:0] step_q;
  logic [2:0] digit_q;
  logic [3:0] live_q;

  logic       grant;
  logic       grant_owner;
  logic [3:0] live_now;
  logic [3:0] live_sel;
  logic [2:0] start_step;
  logic [2:0] nxt_step;

  mul8_rr_arb u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .owner  (grant_owner)
  );

`ifdef ZERO_SKIP_EN
  always_comb live_now = step_live(nib_zero);
`else
  logic unused_nib_zero;
  assign unused_nib_zero = ^nib_zero;
  always_comb live_now = 4'hF;
`endif

  // Next MUL step to run: from CLR search from step 0 using the live flags
  // being captured this cycle; from MUL continue past the current step.
  always_comb begin
    live_sel   = (state_q == CLR) ? live_now : live_q;
    start_step = (state_q == CLR) ? 3'd0 : ({1'b0, step_q} + 3'd1);
    nxt_step   = first_live(live_sel, start_step);
  end

  assign state_dbg = state_q;

  // Outputs are registered: each transition loads the outputs of the state
  // being entered, so they are a clean Moore decode of the state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      step_q      <= 2'd0;
      digit_q     <= 3'd0;
      live_q      <= 4'h0;
      op_sel      <= 1'b0;
      input_sela  <= 1'b0;
      input_selb  <= 1'b0;
      shift_sel   <= SHIFT_0;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      seg_mux_sel <= 3'd0;
      seg_ld      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack         <= 2'b00;
    end else begin
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      seg_ld  <= 1'b0;
      done    <= 1'b0;
      ack     <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= CLR;
            owner_q <= grant_owner;
            op_sel  <= grant_owner;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
          end
        end
        CLR, MUL: begin
          if (state_q == CLR) live_q <= live_now;
          if (nxt_step != NO_STEP) begin
            state_q    <= MUL;
            step_q     <= nxt_step[1:0];
            input_sela <= STEP_SELA[nxt_step[1:0]];
            input_selb <= STEP_SELB[nxt_step[1:0]];
            shift_sel  <= STEP_SHIFT[{nxt_step[1:0], 1'b0} +: 2];
            acc_en     <= 1'b1;
          end else begin
            state_q     <= DISP;
            digit_q     <= 3'd0;
            input_sela  <= 1'b0;
            input_selb  <= 1'b0;
            shift_sel   <= SHIFT_0;
            seg_mux_sel <= 3'd0;
            seg_ld      <= 1'b1;
          end
        end
        DISP: begin
          if (digit_q == LAST_DIGIT) begin
            state_q     <= DONE;
            seg_mux_sel <= 3'd0;
            done        <= 1'b1;
            ack         <= owner_q ? 2'b10 : 2'b01;
            rr_ptr_q    <= ~owner_q;
          end else begin
            digit_q     <= digit_q + 3'd1;
            seg_mux_sel <= digit_q + 3'd1;
            seg_ld      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          op_sel  <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          op_sel  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_rr_sched.sv
// tb_mul8_rr_sched: directed bench for mul8_rr_sched with a transaction-level
// reference model, a model of the external multiply/display datapath, and
// an expected-result queue checked every cycle on the falling edge.
module tb_mul8_rr_sched;

  localparam int DISP = 5;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] nib_zero;
  logic       op_sel;
  logic       input_sela;
  logic       input_selb;
  logic [1:0] shift_sel;
  logic       acc_clr;
  logic       acc_en;
  logic [2:0] seg_mux_sel;
  logic       seg_ld;
  logic       busy;
  logic       done;
  logic [1:0] ack;
  logic [2:0] state_dbg;

  mul8_rr_sched #(.DISP_DIGITS(DISP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .nib_zero    (nib_zero),
    .op_sel      (op_sel),
    .input_sela  (input_sela),
    .input_selb  (input_selb),
    .shift_sel   (shift_sel),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .seg_mux_sel (seg_mux_sel),
    .seg_ld      (seg_ld),
    .busy        (busy),
    .done        (done),
    .ack         (ack),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  a_op [2];
  logic [7:0]  b_op [2];
  logic [15:0] acc;
  int          seg [DISP];
  logic [1:0]  shift_log [$];

  // reference model
  int          rem = 0;
  int          cur_len = 0;
  logic        m_owner = 1'b0;
  logic        m_ptr = 1'b0;
  logic [15:0] exp_q [$];
  int          step_q [$];

  always_comb begin
    nib_zero = {b_op[op_sel][7:4] == 4'h0, b_op[op_sel][3:0] == 4'h0,
                a_op[op_sel][7:4] == 4'h0, a_op[op_sel][3:0] == 4'h0};
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_digit(input logic [15:0] v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < DISP - 1 - i; k++) p = p * 10;
    return (int'(v) / p) % 10;
  endfunction

  function automatic logic [3:0] nib(input logic [7:0] v, input int hi);
    return (hi != 0) ? v[7:4] : v[3:0];
  endfunction

  // Steps performed for operands a,b: step k multiplies a half (k/2) by b
  // half (k%2). Without skipping all four run.
  function automatic bit step_runs(input logic [7:0] a, input logic [7:0] b,
                                   input int k);
`ifdef ZERO_SKIP_EN
    return (nib(a, k / 2) != 4'h0) && (nib(b, k % 2) != 4'h0);
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- model + compare (one process, falling edge) ----------------
  initial begin
    int st;
    logic [7:0]  prod;
    logic [15:0] ev;
    forever begin
      @(negedge clk);
      // Compare this cycle's outputs against the model.
      check("busy", busy, rem > 0);
      check("done", done, rem == 1);
      check("ack", ack, (rem == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      check("acc_clr", acc_clr, (rem > 0) && (rem == cur_len));
      check("acc_en", acc_en, (rem >= DISP + 2) && (rem <= cur_len - 1));
      check("seg_ld", seg_ld, (rem >= 2) && (rem <= DISP + 1));
      if (rem == 0)
        check("idle_outs", {op_sel, input_sela, input_selb, shift_sel, seg_mux_sel}, 0);
      if ((rem >= 2) && (rem <= DISP + 1))
        check("seg_mux_sel", seg_mux_sel, DISP + 1 - rem);
      if ((rem > 0) && (rem == cur_len))
        check("op_sel_clr", op_sel, m_owner);
      if ((rem >= DISP + 2) && (rem <= cur_len - 1)) begin
        check("op_sel_mul", op_sel, m_owner);
        if (step_q.size() == 0) begin
          check("step_avail", 0, 1);
        end else begin
          st = step_q.pop_front();
          check("sela", input_sela, st / 2);
          check("selb", input_selb, st % 2);
          check("shift", shift_sel, (st / 2) + (st % 2));
        end
      end
      if (acc_en) shift_log.push_back(shift_sel);
      if (rem == 1) begin
        check("steps_left", step_q.size(), 0);
        if (exp_q.size() == 0) begin
          check("exp_avail", 0, 1);
        end else begin
          ev = exp_q.pop_front();
          check("product", acc, ev);
          for (int i = 0; i < DISP; i++) check("digit", seg[i], dec_digit(ev, i));
        end
      end
      // External datapath reacts to this cycle's controls at the next edge.
      prod = nib(a_op[op_sel], int'(input_sela)) * nib(b_op[op_sel], int'(input_selb));
      if (acc_clr) acc = 16'h0;
      else if (acc_en) acc = acc + (16'(prod) << (4 * shift_sel));
      if (seg_ld && (seg_mux_sel < DISP)) seg[seg_mux_sel] = dec_digit(acc, int'(seg_mux_sel));
      // Advance the model with the inputs the DUT will sample at the edge.
      if (!rst) begin
        rem = 0;
        cur_len = 0;
        m_ptr = 1'b0;
        exp_q.delete();
        step_q.delete();
      end else if (rem > 0) begin
        rem--;
        if (rem == 1) m_ptr = ~m_owner;
      end else if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? m_ptr : req[1];
        cur_len = 2 + DISP;
        for (int k = 0; k < 4; k++) begin
          if (step_runs(a_op[m_owner], b_op[m_owner], k)) begin
            step_q.push_back(k);
            cur_len++;
          end
        end
        rem = cur_len;
        exp_q.push_back(16'(a_op[m_owner]) * 16'(b_op[m_owner]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ack appears; cnt starts from start.
  task automatic wait_ack(input int start, output int cnt, output logic [1:0] got);
    cnt = start;
    got = 2'b00;
    while (cnt < 60) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ack != 2'b00) begin
        got = ack;
        break;
      end
    end
    if (got == 2'b00) check("ack_timeout", cnt, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    req = 2'b00;
    tick(n);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    logic [1:0]  got;
    logic [1:0]  acks [$];
    int          lit_dig [5];
    logic [1:0]  lit_shift [4];
    logic [1:0]  lit_ack [4];
    lit_dig   = '{6, 5, 0, 2, 5};
    lit_shift = '{2'd0, 2'd1, 2'd1, 2'd2};
    lit_ack   = '{2'b01, 2'b10, 2'b01, 2'b10};
    a_op[0] = 8'h00; b_op[0] = 8'h00;
    a_op[1] = 8'h00; b_op[1] = 8'h00;
    acc = 16'h0;
    for (int i = 0; i < DISP; i++) seg[i] = 0;
    rst = 1'b0;
    req = 2'b00;

    // Reset for two cycles: everything low.
    tick(2);
    check("rst_outs", {op_sel, input_sela, input_selb, shift_sel, acc_clr, acc_en,
                       seg_mux_sel, seg_ld, busy, done, ack}, 0);
    rst = 1'b1;
    tick(2);

    // FF x FF from requester 0.
    a_op[0] = 8'hFF; b_op[0] = 8'hFF;
    shift_log.delete();
    req = 2'b01;
    wait_ack(0, cnt, got);
    req = 2'b00;
    check("lat_ff", cnt, 11);
    check("ack_ff", got, 2'b01);
    check("acc_ff", acc, 16'hFE01);
    for (int i = 0; i < 5; i++) check("dig_ff", seg[i], lit_dig[i]);
    check("shift_cnt_ff", shift_log.size(), 4);
    for (int i = 0; i < 4 && i < shift_log.size(); i++)
      check("shift_ff", shift_log[i], lit_shift[i]);
    tick(3);

    // Both requesting continuously: strict alternation starting at 0.
    do_reset(2);
    a_op[0] = 8'h12; b_op[0] = 8'h34;
    a_op[1] = 8'hAB; b_op[1] = 8'hCD;
    req = 2'b11;
    acks.delete();
    for (int c = 0; c < 100 && acks.size() < 4; c++) begin
      @(posedge clk);
      #1;
      if (ack != 2'b00) acks.push_back(ack);
    end
    req = 2'b00;
    check("alt_cnt", acks.size(), 4);
    for (int i = 0; i < 4 && i < acks.size(); i++) check("alt_ack", acks[i], lit_ack[i]);
    tick(3);

    // Reset in MUL step 2, then requester 1 gets a full sequence.
    do_reset(2);
    a_op[0] = 8'hFF; b_op[0] = 8'hFF;
    a_op[1] = 8'h9C; b_op[1] = 8'h47;
    req = 2'b01;
    tick(4);
    check("mid_busy", busy, 1);
    check("mid_sel", {input_sela, input_selb}, 2'b10);
    rst = 1'b0;
    req = 2'b10;
    tick(1);
    check("abort_outs", {busy, acc_en, done, ack, op_sel, shift_sel}, 0);
    rst = 1'b1;
    wait_ack(0, cnt, got);
    req = 2'b00;
    check("lat_after_rst", cnt, 11);
    check("ack_after_rst", got, 2'b10);
    check("acc_after_rst", acc, 16'h2B44);
    tick(3);

    // Request dropped after being sampled still completes.
    a_op[0] = 8'h3A; b_op[0] = 8'h05;
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_ack(1, cnt, got);
    check("lat_drop", cnt, 11);
    check("ack_drop", got, 2'b01);
    check("acc_drop", acc, 16'h0122);
    tick(3);

`ifdef ZERO_SKIP_EN
    a_op[0] = 8'h0F; b_op[0] = 8'h30;
    shift_log.delete();
    req = 2'b01;
    wait_ack(0, cnt, got);
    req = 2'b00;
    check("lat_skip", cnt, 8);
    check("acc_skip", acc, 16'h02D0);
    check("shift_skip_n", shift_log.size(), 1);
    tick(3);

    a_op[0] = 8'h00; b_op[0] = 8'h5A;
    shift_log.delete();
    req = 2'b01;
    wait_ack(0, cnt, got);
    req = 2'b00;
    check("lat_zero", cnt, 7);
    check("acc_zero", acc, 16'h0000);
    check("acc_en_zero", shift_log.size(), 0);
    tick(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
